prob_3_31_c: RTL and testbench
==============================

Name: prob_3_31_c

Overview:
- Evaluates one fixed 4-variable Boolean function F(A,B,C,D) = Σm(2,4,10,12,14).
- The function is selectable by a truth-table parameter.
- Provides a combinational result `f` and a registered, valid-qualified copy for synchronous consumers.
- Used as a small leaf block: a decode or predicate unit inside larger control logic.

Parameters:
- TT, 16'h5414, truth table. Bit i is F for minterm i = {a,b,c,d}, with a as MSB. Default sets bits 2, 4, 10, 12, 14.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- f  output  1  combinational result F(a,b,c,d)
- a  input  1  variable A (MSB of minterm index)
- b  input  1  variable B
- c  input  1  variable C
- d  input  1  variable D (LSB of minterm index)
- in_valid  input  1  qualifies a,b,c,d for registration
- f_q  output  1  registered F
- idx_q  output  4  registered minterm index {a,b,c,d}
- out_valid  output  1  f_q/idx_q hold a fresh result this cycle

Behaviour:
- Index idx = {a,b,c,d}; f = TT[idx].
  - f is purely combinational and independent of clk, rst and in_valid.
  - f settles within the same timestep as an input change; no latch.
- Default function: f=1 only for idx 2, 4, 10, 12, 14 (0010, 0100, 1010, 1100, 1110); f=0 for all others.
  - Equivalent form: F = D'(A'B'C + BC' + AC) restricted to those minterms, i.e. exactly the five minterms above.
  - Implementation is by table index, not hand-minimised logic.
- Registered path, 1-cycle latency:
  - On a rising clk edge with in_valid=1: f_q <= TT[idx], idx_q <= idx, out_valid <= 1.
  - On a rising clk edge with in_valid=0: f_q and idx_q hold their values, out_valid <= 0.
- Reset:
  - On a rising clk edge with rst=1: f_q=0, idx_q=0, out_valid=0.
  - rst has priority over in_valid.
  - A reset asserted mid-stream discards the pending capture.
  - f remains live during reset.
- Inputs X/Z: f may be X. Registered outputs capture only when in_valid=1.
- No backpressure; every valid input is accepted.

Optional Feature:
- Macro PROB_3_31_C_HITCNT_EN.
- Defined:
  - Adds output hit_cnt [4:0].
  - Increments by 1 on each clk edge where in_valid=1 and TT[idx]=1.
  - Saturates at 31 (no wrap).
  - Cleared to 0 by rst.
  - Increment and out_valid update in the same edge.
- Undefined: port hit_cnt and its counter are absent; all other behaviour is identical.

Decomposition:
- Package prob_3_31_c_pkg holds:
  - typedef minterm_t = logic [3:0]
  - localparam TT_DEFAULT = 16'h5414
  - function tt_lookup(tt, idx)
- One sub-module, prob_3_31_c_lut: purely combinational index-to-bit lookup, instantiated once to drive both f and the f_q input.
- All sequential logic (registers, optional counter) stays in the top module.

Test Plan:
- Exhaustive combinational sweep: drive {a,b,c,d} 0000→1111, 10 ns per step, rst=0 → f=1 exactly at 0010, 0100, 1010, 1100, 1110; f=0 at the other 11 codes.
- Registered latency: rst high 2 cycles, then in_valid=1 with idx=0100 at edge N, and idx=0101 at edge N+1 → after edge N: f_q=1, idx_q=4, out_valid=1; after edge N+1: f_q=0, idx_q=5.
- Hold: in_valid=0 for 3 cycles after capturing idx=1010 → f_q=1 and idx_q=10 hold; out_valid=0 from the first idle edge.
- Reset mid-stream: rst=1 together with in_valid=1 and idx=1100 → after that edge f_q=0, idx_q=0, out_valid=0; f still reads 1 combinationally.
- Parameter override TT=16'h8001 → f=1 only at 0000 and 1111, for both combinational and registered outputs.
- With PROB_3_31_C_HITCNT_EN:
  - One valid sweep of all 16 codes → hit_cnt=5.
  - Repeat 7 sweeps → hit_cnt saturates at 31.
  - rst → hit_cnt=0.

Source files
------------

// File: rtl/prob_3_31_c_pkg.sv
// prob_3_31_c_pkg: shared types, default truth table and lookup helper for prob_3_31_c
package prob_3_31_c_pkg;
  typedef logic [3:0] minterm_t;
  localparam logic [15:0] TT_DEFAULT = 16'h5414;
  function automatic logic tt_lookup(input logic [15:0] tt, input minterm_t idx);
    return tt[idx];
  endfunction
endpackage

// File: rtl/prob_3_31_c_if.sv
// prob_3_31_c_if: operand/result bundle for prob_3_31_c; hit_cnt present only with PROB_3_31_C_HITCNT_EN
interface prob_3_31_c_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic in_valid;
  logic f;
  logic f_q;
  prob_3_31_c_pkg::minterm_t idx_q;
  logic out_valid;
`ifdef PROB_3_31_C_HITCNT_EN
  logic [4:0] hit_cnt;
  modport master(output a, b, c, d, in_valid, input f, f_q, idx_q, out_valid, hit_cnt);
  modport slave(input a, b, c, d, in_valid, output f, f_q, idx_q, out_valid, hit_cnt);
`else
  modport master(output a, b, c, d, in_valid, input f, f_q, idx_q, out_valid);
  modport slave(input a, b, c, d, in_valid, output f, f_q, idx_q, out_valid);
`endif
endinterface

// File: rtl/prob_3_31_c_lut.sv
// prob_3_31_c_lut: combinational minterm-index to truth-table bit lookup
module prob_3_31_c_lut
  import prob_3_31_c_pkg::*;
#(
  parameter logic [15:0] TT = TT_DEFAULT
) (
  input  minterm_t idx,
  output logic     f
);
  assign f = tt_lookup(TT, idx);
endmodule

// File: rtl/prob_3_31_c.sv
// prob_3_31_c: table-driven 4-input Boolean function with combinational and registered, valid-qualified result.
// Optional saturating hit counter enabled by PROB_3_31_C_HITCNT_EN.
module prob_3_31_c
  import prob_3_31_c_pkg::*;
#(
  parameter logic [15:0] TT = TT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  prob_3_31_c_if.slave  bus
);
  minterm_t idx;
  logic     hit;
  assign idx = {bus.a, bus.b, bus.c, bus.d};
  prob_3_31_c_lut #(.TT(TT)) u_lut (.idx(idx), .f(hit));
  assign bus.f = hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.f_q       <= 1'b0;
      bus.idx_q     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.f_q   <= hit;
        bus.idx_q <= idx;
      end
    end
  end
`ifdef PROB_3_31_C_HITCNT_EN
  always_ff @(posedge clk) begin
    if (rst) bus.hit_cnt <= '0;
    else if (bus.in_valid && hit && bus.hit_cnt != 5'd31) bus.hit_cnt <= bus.hit_cnt + 5'd1;
  end
`endif
endmodule

// File: tb/tb_prob_3_31_c.sv
// tb_prob_3_31_c: directed self-checking bench for prob_3_31_c (default TT and TT=16'h8001)
module tb_prob_3_31_c;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  prob_3_31_c_if bus ();
  prob_3_31_c_if bus2 ();
  assign bus2.a = bus.a;
  assign bus2.b = bus.b;
  assign bus2.c = bus.c;
  assign bus2.d = bus.d;
  assign bus2.in_valid = bus.in_valid;
  prob_3_31_c dut (.clk(clk), .rst(rst), .bus(bus));
  prob_3_31_c #(.TT(16'h8001)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_idx(input logic [3:0] v);
    {bus.a, bus.b, bus.c, bus.d} = v;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    set_idx(4'd0);
    tick();
    tick();
    chk("rst_f_q", bus.f_q, 0);
    chk("rst_idx_q", bus.idx_q, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_idx(4'(i));
      #10;
      chk($sformatf("comb_f_%0d", i), bus.f, (i == 2 || i == 4 || i == 10 || i == 12 || i == 14) ? 1 : 0);
      chk($sformatf("comb_f_tt8001_%0d", i), bus2.f, (i == 0 || i == 15) ? 1 : 0);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    set_idx(4'd4);
    tick();
    chk("lat_f_q_4", bus.f_q, 1);
    chk("lat_idx_q_4", bus.idx_q, 4);
    chk("lat_ov_4", bus.out_valid, 1);
    set_idx(4'd5);
    tick();
    chk("lat_f_q_5", bus.f_q, 0);
    chk("lat_idx_q_5", bus.idx_q, 5);
    chk("lat_ov_5", bus.out_valid, 1);
    set_idx(4'd10);
    tick();
    chk("cap_f_q_10", bus.f_q, 1);
    chk("cap_idx_q_10", bus.idx_q, 10);
    bus.in_valid = 1'b0;
    set_idx(4'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_f_q_%0d", i), bus.f_q, 1);
      chk($sformatf("hold_idx_q_%0d", i), bus.idx_q, 10);
      chk($sformatf("hold_ov_%0d", i), bus.out_valid, 0);
    end
    bus.in_valid = 1'b1;
    set_idx(4'd12);
    rst = 1'b1;
    tick();
    chk("midrst_f_q", bus.f_q, 0);
    chk("midrst_idx_q", bus.idx_q, 0);
    chk("midrst_ov", bus.out_valid, 0);
    chk("midrst_f_live", bus.f, 1);
    rst = 1'b0;
    set_idx(4'd15);
    tick();
    chk("tt8001_f_q_15", bus2.f_q, 1);
    chk("dflt_f_q_15", bus.f_q, 0);
    set_idx(4'd0);
    tick();
    chk("tt8001_f_q_0", bus2.f_q, 1);
    chk("tt8001_idx_q_0", bus2.idx_q, 0);
    set_idx(4'd4);
    tick();
    chk("tt8001_f_q_4", bus2.f_q, 0);
    chk("dflt_f_q_4", bus.f_q, 1);
`ifdef PROB_3_31_C_HITCNT_EN
    rst = 1'b1;
    tick();
    chk("hit_rst0", bus.hit_cnt, 0);
    rst = 1'b0;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 16; i++) begin
        set_idx(4'(i));
        tick();
      end
      if (s == 0) chk("hit_sweep1", bus.hit_cnt, 5);
      if (s == 0) chk("hit2_sweep1", bus2.hit_cnt, 2);
      if (s == 5) chk("hit_sweep6", bus.hit_cnt, 30);
    end
    chk("hit_sat", bus.hit_cnt, 31);
    rst = 1'b1;
    tick();
    chk("hit_rst", bus.hit_cnt, 0);
    rst = 1'b0;
`endif
    bus.in_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
